fpf_cac_seq_encoder: RTL and testbench
======================================

// Module: fpf_cac_seq_encoder
// PURPOSE
//  Parametrised, bit-serial FNS-based forbidden-pattern-free (3C) CAC encoder for a TSV bundle of N_WIRES.
//  Converts a binary word into an N_WIRES codeword with no 101/010 triple on adjacent wires, MSB-first, one wire per cycle.
//  Sits between the link data source and the TSV drivers. The TSV bus changes only when a completed codeword is released.
//  The existing FNS decoder family recovers the data: sum of wire weights.
// PARAMETERS
//  N_WIRES  23                          TSV count, legal range 3..40
//  DATA_W   $clog2(fib(N_WIRES+2))      input width; fixed by N_WIRES, never overridden
// PORTS
//  clock      in   1        rising-edge clock
//  reset_n    in   1        synchronous active-low reset
//  in_valid   in   1        input word offered
//  in_ready   out  1        encoder idle, accepts word
//  in_data    in   DATA_W   binary value, legal 0..fib(N_WIRES+2)-1
//  out_valid  out  1        codeword on tsv is complete and pending
//  out_ready  in   1        downstream takes codeword
//  tsv        out  N_WIRES  codeword driven to TSVs (held between words)
//  range_err  out  1        pending codeword came from an out-of-range input
// BEHAVIOUR
//  Weights: wire k carries w_k = fib(k+1), with fib(1)=fib(2)=1. Value = sum of w_k over set wires.
//  Reset (reset_n=0 at clock edge): state IDLE, in_ready=1, out_valid=0, tsv=0, range_err=0, residue=0.
//  FSM IDLE -> ENC -> HOLD -> IDLE:
//   IDLE: in_valid&&in_ready: latch residue r=in_data, k=N_WIRES-1, prev=0, forced=0 -> ENC.
//     Out-of-range input: range_err is set, r is forced to 0, and the word encodes as all-zero.
//   ENC: one wire decided per cycle into a shadow register (tsv unchanged). Rules:
//     forced=1: d_k=prev; forced<=0.
//     free, prev=0: d_k = (r >= fib(k+2)).
//       If d_k=1 and k>0: forced<=1, because a 0->1 transition must repeat on the next wire.
//     free, prev=1: d_k = (r >= fib(k+1)).
//       If d_k=0 and k>0: forced<=1.
//     If d_k=1: r <= r - w_k. prev<=d_k. k<=k-1. After k=0 -> HOLD.
//   HOLD entry cycle: tsv<=shadow, out_valid<=1. in_ready=0 in ENC and HOLD.
//   HOLD: out_valid&&out_ready -> out_valid<=0 and range_err<=0 next edge, then IDLE.
//     tsv keeps its value (no spurious transitions).
//  Latency: input accept to out_valid = N_WIRES+1 cycles. Throughput: one word per N_WIRES+2 cycles minimum.
//  Residue never underflows for legal input. Assertion: r==0 on entering HOLD.
//  The MSB uses virtual prev=0. The conservative forcing at the top still covers the full range 0..fib(N_WIRES+2)-1.
//  out_ready held high: the HOLD->IDLE handoff costs exactly 1 cycle.
//  in_valid while busy: ignored. The source holds the word until in_ready.
//  Reset mid-ENC or mid-HOLD: the word is dropped. tsv returns to 0 on the same edge.
//  Arithmetic: residue is DATA_W bits, unsigned. Fibonacci constants come from the package function, evaluated at elaboration.
// STRUCTURE
//  fns_pkg: function automatic fib(int n); typedef enum logic[1:0] {IDLE,ENC,HOLD} fpf_state_t;
//    also localparam helper fpf_data_w(n) = $clog2(fib(n+2)).
//  Sub-module fpf_bit_decide (combinational):
//    inputs r, k, prev, forced; outputs d, next_r, next_forced.
//    Reused by a future multi-bit-per-cycle variant.
//  Top holds the FSM, wire counter, residue, shadow and tsv registers.
// TESTING
//  N_WIRES=5, in_data=7 -> after 6 cycles out_valid=1, tsv=5'b01111, range_err=0.
//  N_WIRES=5, in_data=8 then 9 back-to-back, out_ready=1 -> tsv=5'b11000, then 5'b11001.
//    Each word takes 7 cycles accept-to-accept.
//  N_WIRES=23: in_data=0 -> tsv=0; in_data=75024 -> tsv=23'h7FFFFF. Both range_err=0.
//  N_WIRES=23: in_data=75025 -> tsv=0, range_err=1, cleared after the out_ready handshake.
//  out_ready=0 for 10 cycles in HOLD -> tsv and out_valid stable, in_ready=0.
//    reset_n=0 mid-ENC -> next cycle tsv=0, in_ready=1.
//  100k random legal words at N_WIRES=23 and N_WIRES=8, out_ready randomly throttled:
//    weighted sum of tsv equals in_data.
//    No 101/010 on any adjacent wire triple.
//    tsv changes only on HOLD entry.

Source files
------------

// File: rtl/fns_pkg.sv
// Shared definitions for the FNS-based forbidden-pattern-free encoder family:
// state encoding and the Fibonacci helpers used to size and weight the wires.
package fns_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ENC,
        HOLD
    } fpf_state_t;

    localparam int FPF_MIN_WIRES = 3;
    localparam int FPF_MAX_WIRES = 40;

    // fib(0)=0, fib(1)=fib(2)=1; fib(42) still fits a signed int.
    function automatic int fib(int n);
        int a;
        int b;
        int t;
        a = 0;
        b = 1;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int fpf_data_w(int n);
        return $clog2(fib(n + 2));
    endfunction

endpackage

// File: rtl/fpf_bit_decide.sv
// Combinational decision for one wire of the 3C-free FNS code: chooses the wire bit,
// the residue left for the lower wires and whether the next wire must repeat this one.
module fpf_bit_decide
    import fns_pkg::*;
#(
    parameter int N_WIRES = 23,
    parameter int DATA_W  = fpf_data_w(N_WIRES),
    parameter int K_W     = $clog2(N_WIRES)
) (
    input  logic [DATA_W-1:0] r_i,
    input  logic [K_W-1:0]    k_i,
    input  logic              prev_i,
    input  logic              forced_i,
    output logic              d_o,
    output logic [DATA_W-1:0] nextR_o,
    output logic              nextForced_o
);

    // weightTab[k] = fib(k+1) is the wire weight; riseTab[k] = fib(k+2) is the
    // stricter threshold for a 0->1 step, which also pays for the forced repeat below it.
    logic [DATA_W-1:0] weightTab [N_WIRES];
    logic [DATA_W-1:0] riseTab   [N_WIRES];
    logic              kNonZero;

    for (genvar g = 0; g < N_WIRES; g++) begin : g_tab
        assign weightTab[g] = DATA_W'(fib(g + 1));
        assign riseTab[g]   = DATA_W'(fib(g + 2));
    end

    assign kNonZero = (k_i != '0);

    always_comb begin
        d_o          = 1'b0;
        nextForced_o = 1'b0;
        if (forced_i) begin
            d_o = prev_i;
        end else if (!prev_i) begin
            d_o          = (r_i >= riseTab[k_i]);
            nextForced_o = d_o && kNonZero;
        end else begin
            d_o          = (r_i >= weightTab[k_i]);
            nextForced_o = !d_o && kNonZero;
        end
        nextR_o = d_o ? (r_i - weightTab[k_i]) : r_i;
    end

endmodule

// File: rtl/fpf_cac_seq_encoder.sv
// Bit-serial 3C-free CAC encoder: decides one TSV wire per cycle MSB first into a shadow
// register and only drives the TSV bus once the whole codeword is known.
module fpf_cac_seq_encoder
    import fns_pkg::*;
#(
    parameter int  N_WIRES = 23,
    localparam int DATA_W  = fpf_data_w(N_WIRES)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_WIRES-1:0] tsv,
    output logic               range_err
);

    localparam int              K_W        = $clog2(N_WIRES);
    localparam logic [K_W-1:0]  K_TOP      = K_W'(N_WIRES - 1);
    localparam logic [DATA_W:0] CODE_LIMIT = (DATA_W + 1)'(fib(N_WIRES + 2));

    fpf_state_t         state_q;
    logic [K_W-1:0]     k_q;
    logic [DATA_W-1:0]  residue_q;
    logic [DATA_W-1:0]  residue_d;
    logic               prev_q;
    logic               forced_q;
    logic               forced_d;
    logic               bit_d;
    logic [N_WIRES-1:0] shadow_q;
    logic [N_WIRES-1:0] shadow_d;
    logic [N_WIRES-1:0] tsv_q;
    logic               inReady_q;
    logic               outValid_q;
    logic               rangeErr_q;
    logic               inRange;

    fpf_bit_decide #(
        .N_WIRES (N_WIRES),
        .DATA_W  (DATA_W),
        .K_W     (K_W)
    ) u_decide (
        .r_i          (residue_q),
        .k_i          (k_q),
        .prev_i       (prev_q),
        .forced_i     (forced_q),
        .d_o          (bit_d),
        .nextR_o      (residue_d),
        .nextForced_o (forced_d)
    );

    assign inRange = ({1'b0, in_data} < CODE_LIMIT);

    always_comb begin
        shadow_d       = shadow_q;
        shadow_d[k_q]  = bit_d;
    end

    // The last decision is merged straight into tsv so the bus moves exactly once per word.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            k_q        <= '0;
            residue_q  <= '0;
            prev_q     <= 1'b0;
            forced_q   <= 1'b0;
            shadow_q   <= '0;
            tsv_q      <= '0;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
            rangeErr_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q    <= ENC;
                        inReady_q  <= 1'b0;
                        k_q        <= K_TOP;
                        prev_q     <= 1'b0;
                        forced_q   <= 1'b0;
                        shadow_q   <= '0;
                        residue_q  <= inRange ? in_data : '0;
                        rangeErr_q <= !inRange;
                    end
                end
                ENC: begin
                    shadow_q  <= shadow_d;
                    residue_q <= residue_d;
                    prev_q    <= bit_d;
                    forced_q  <= forced_d;
                    k_q       <= k_q - 1'b1;
                    if (k_q == '0) begin
                        state_q    <= HOLD;
                        tsv_q      <= shadow_d;
                        outValid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_q    <= IDLE;
                        outValid_q <= 1'b0;
                        rangeErr_q <= 1'b0;
                        inReady_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = inReady_q;
    assign out_valid = outValid_q;
    assign tsv       = tsv_q;
    assign range_err = rangeErr_q;

    // Every legal value must be fully consumed by the time the LSB wire is decided.
    a_residue_empty: assert property (@(posedge clock) disable iff (!reset_n)
        (state_q == ENC && k_q == '0) |-> (residue_d == '0));

endmodule

// File: tb/tb_fpf_cac_seq_encoder.sv
// Scoreboard bench for the serial 3C-free encoder: three widths run side by side and every
// released codeword is judged by its Fibonacci weight, its wire patterns and its timing.
module tb_fpf_cac_seq_encoder;

    function automatic int fibTb(int n);
        int a;
        int b;
        int t;
        a = 0;
        b = 1;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    localparam int NW0 = 5;
    localparam int NW1 = 23;
    localparam int NW2 = 8;
    localparam int DW0 = $clog2(fibTb(NW0 + 2));
    localparam int DW1 = $clog2(fibTb(NW1 + 2));
    localparam int DW2 = $clog2(fibTb(NW2 + 2));

    typedef struct {
        int         data;
        bit         rangeErr;
        bit         exact;
        logic [22:0] exactTsv;
        int         acceptCycle;
    } sbEntry_t;

    sbEntry_t sbQ0[$];
    sbEntry_t sbQ1[$];
    sbEntry_t sbQ2[$];

    logic        clock = 1'b0;
    logic        resetN;
    logic [2:0]  inValid;
    logic [16:0] inData [3];
    logic [2:0]  fixedReady;
    logic [2:0]  rndReady;
    logic [2:0]  throttle;
    wire  [2:0]  outReady = (throttle & rndReady) | (~throttle & fixedReady);
    wire  [2:0]  inReady;
    wire  [2:0]  outValid;
    wire  [2:0]  rangeErr;
    wire  [NW0-1:0] tsv0;
    wire  [NW1-1:0] tsv1;
    wire  [NW2-1:0] tsv2;
    logic [22:0] tsvV [3];

    int totalCnt = 0;
    int badCnt   = 0;
    int cycleCnt = 0;
    bit rstAtEdge = 1'b1;

    fpf_cac_seq_encoder #(.N_WIRES(NW0)) dut0 (
        .clock(clock), .reset_n(resetN), .in_valid(inValid[0]), .in_ready(inReady[0]),
        .in_data(inData[0][DW0-1:0]), .out_valid(outValid[0]), .out_ready(outReady[0]),
        .tsv(tsv0), .range_err(rangeErr[0]));

    fpf_cac_seq_encoder #(.N_WIRES(NW1)) dut1 (
        .clock(clock), .reset_n(resetN), .in_valid(inValid[1]), .in_ready(inReady[1]),
        .in_data(inData[1][DW1-1:0]), .out_valid(outValid[1]), .out_ready(outReady[1]),
        .tsv(tsv1), .range_err(rangeErr[1]));

    fpf_cac_seq_encoder #(.N_WIRES(NW2)) dut2 (
        .clock(clock), .reset_n(resetN), .in_valid(inValid[2]), .in_ready(inReady[2]),
        .in_data(inData[2][DW2-1:0]), .out_valid(outValid[2]), .out_ready(outReady[2]),
        .tsv(tsv2), .range_err(rangeErr[2]));

    always_comb begin
        tsvV[0] = 23'(tsv0);
        tsvV[1] = tsv1;
        tsvV[2] = 23'(tsv2);
    end

    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cycleCnt  = cycleCnt + 1;
        rstAtEdge = !resetN;
    end

    initial begin
        rndReady = 3'b111;
        forever begin
            @(posedge clock);
            #1;
            rndReady = 3'($urandom);
        end
    end

    function automatic int nwOf(int i);
        case (i)
            0:       return NW0;
            1:       return NW1;
            default: return NW2;
        endcase
    endfunction

    function automatic int dwOf(int i);
        case (i)
            0:       return DW0;
            1:       return DW1;
            default: return DW2;
        endcase
    endfunction

    // The value a codeword represents, straight from the wire weights fib(k+1).
    function automatic int weightedSum(logic [22:0] t, int n);
        int s;
        s = 0;
        for (int k = 0; k < n; k++) begin
            if (t[k]) s = s + fibTb(k + 1);
        end
        return s;
    endfunction

    function automatic bit patternFree(logic [22:0] t, int n);
        for (int k = 0; k + 2 < n; k++) begin
            if (t[k] != t[k+1] && t[k+1] != t[k+2]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int sbSize(int i);
        case (i)
            0:       return sbQ0.size();
            1:       return sbQ1.size();
            default: return sbQ2.size();
        endcase
    endfunction

    function automatic sbEntry_t sbFront(int i);
        case (i)
            0:       return sbQ0[0];
            1:       return sbQ1[0];
            default: return sbQ2[0];
        endcase
    endfunction

    task automatic sbPush(input int i, input sbEntry_t e);
        case (i)
            0:       sbQ0.push_back(e);
            1:       sbQ1.push_back(e);
            default: sbQ2.push_back(e);
        endcase
    endtask

    task automatic sbPop(input int i);
        case (i)
            0:       void'(sbQ0.pop_front());
            1:       void'(sbQ1.pop_front());
            default: void'(sbQ2.pop_front());
        endcase
    endtask

    task automatic checkOutput(input string name, input int inst, input int actual, input int expected);
        totalCnt = totalCnt + 1;
        if (actual != expected) begin
            badCnt = badCnt + 1;
            $display("[TB] FAIL %s inst%0d: actual=%0d required=%0d", name, inst, actual, expected);
        end
    endtask

    task automatic reportFail(input string name, input int inst);
        totalCnt = totalCnt + 1;
        badCnt   = badCnt + 1;
        $display("[TB] FAIL %s inst%0d: actual=missing required=present", name, inst);
    endtask

    // Offers one word and records its expectation the cycle the handshake happens.
    task automatic applyStimulus(input int inst, input int data, input bit exact,
                                 input logic [22:0] exactTsv, output int acceptCycle);
        sbEntry_t e;
        bit done;
        done         = 1'b0;
        acceptCycle  = -1;
        inValid[inst] = 1'b1;
        inData[inst]  = 17'(data);
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clock);
            if (inReady[inst] && resetN) begin
                e.data        = data;
                e.rangeErr    = (data >= fibTb(nwOf(inst) + 2));
                e.exact       = exact;
                e.exactTsv    = exactTsv;
                e.acceptCycle = cycleCnt;
                sbPush(inst, e);
                acceptCycle = cycleCnt;
                done        = 1'b1;
            end
        end
        @(posedge clock);
        #1;
        inValid[inst] = 1'b0;
        if (!done) reportFail("acceptTimeout", inst);
    endtask

    task automatic waitIdle(input int inst);
        bit idle;
        idle = 1'b0;
        for (int c = 0; c < 300 && !idle; c++) begin
            @(negedge clock);
            idle = (sbSize(inst) == 0) && inReady[inst];
        end
        if (!idle) reportFail("idleTimeout", inst);
        @(posedge clock);
        #1;
    endtask

    task automatic randomRun(input int inst, input int words);
        int limit;
        int maxVal;
        int data;
        int ac;
        limit  = fibTb(nwOf(inst) + 2);
        maxVal = (1 << dwOf(inst)) - 1;
        for (int n = 0; n < words; n++) begin
            repeat ($urandom_range(2, 0)) @(posedge clock);
            #1;
            if ($urandom_range(15, 0) == 0) data = int'($urandom_range(maxVal, limit));
            else                            data = int'($urandom_range(limit - 1, 0));
            applyStimulus(inst, data, 1'b0, 23'd0, ac);
        end
    endtask

    logic [2:0][22:0] lastTsv      = '0;
    logic [2:0]       lastOutValid = '0;
    logic [2:0]       pendingClr   = '0;

    // Monitor: judges each released codeword independently of how it was stimulated.
    always @(negedge clock) begin : monitor
        sbEntry_t e;
        for (int i = 0; i < 3; i++) begin
            if (resetN && !rstAtEdge) begin
                if (tsvV[i] != lastTsv[i])
                    checkOutput("tsvMovesOnlyOnHoldEntry", i, {outValid[i], lastOutValid[i]}, 2);
                if (pendingClr[i]) begin
                    checkOutput("validClearedAfterTake", i, outValid[i], 0);
                    checkOutput("rangeErrClearedAfterTake", i, rangeErr[i], 0);
                end
                if (outValid[i] && !lastOutValid[i]) begin
                    if (sbSize(i) == 0) reportFail("unexpectedOutValid", i);
                    else begin
                        e = sbFront(i);
                        checkOutput("acceptToValidLatency", i, cycleCnt - e.acceptCycle, nwOf(i) + 1);
                    end
                end
                if (outValid[i] && outReady[i]) begin
                    if (sbSize(i) == 0) reportFail("unexpectedTake", i);
                    else begin
                        e = sbFront(i);
                        sbPop(i);
                        checkOutput("rangeErr", i, rangeErr[i], e.rangeErr);
                        if (e.rangeErr) checkOutput("tsvZeroOnRangeErr", i, tsvV[i], 0);
                        else            checkOutput("weightedSum", i, weightedSum(tsvV[i], nwOf(i)), e.data);
                        checkOutput("patternFree", i, patternFree(tsvV[i], nwOf(i)), 1);
                        if (e.exact) checkOutput("exactTsv", i, tsvV[i], e.exactTsv);
                    end
                end
                pendingClr[i] <= outValid[i] && outReady[i];
            end else begin
                pendingClr[i] <= 1'b0;
            end
            lastTsv[i]      <= tsvV[i];
            lastOutValid[i] <= outValid[i];
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog inst0: actual=timeout required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int a0;
        int a1;
        int a2;
        logic [22:0] held;
        bit seen;

        resetN     = 1'b0;
        inValid    = '0;
        throttle   = '0;
        fixedReady = 3'b111;
        for (int i = 0; i < 3; i++) inData[i] = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            checkOutput("resetInReady", i, inReady[i], 1);
            checkOutput("resetOutValid", i, outValid[i], 0);
            checkOutput("resetTsv", i, tsvV[i], 0);
            checkOutput("resetRangeErr", i, rangeErr[i], 0);
        end
        @(posedge clock);
        #1;
        resetN = 1'b1;
        @(posedge clock);
        #1;

        $display("[TB] directed words on the 5-wire encoder");
        applyStimulus(0, 7, 1'b1, 23'b01111, a0);
        waitIdle(0);
        applyStimulus(0, 8, 1'b1, 23'b11000, a1);
        applyStimulus(0, 9, 1'b1, 23'b11001, a2);
        checkOutput("acceptToAccept", 0, a2 - a1, NW0 + 2);
        waitIdle(0);

        $display("[TB] range boundaries on the 23-wire encoder");
        applyStimulus(1, 0, 1'b1, 23'd0, a0);
        applyStimulus(1, 75024, 1'b1, 23'h7FFFFF, a0);
        applyStimulus(1, 75025, 1'b1, 23'd0, a0);
        waitIdle(1);

        $display("[TB] downstream stall while holding a codeword");
        fixedReady[1] = 1'b0;
        applyStimulus(1, 12345, 1'b0, 23'd0, a0);
        seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clock);
            seen = outValid[1];
        end
        if (!seen) reportFail("holdValidTimeout", 1);
        held = tsvV[1];
        repeat (10) begin
            @(negedge clock);
            checkOutput("holdTsvStable", 1, tsvV[1], held);
            checkOutput("holdOutValid", 1, outValid[1], 1);
            checkOutput("holdInReady", 1, inReady[1], 0);
        end
        fixedReady[1] = 1'b1;
        waitIdle(1);

        $display("[TB] reset in the middle of encoding");
        applyStimulus(1, 50000, 1'b0, 23'd0, a0);
        repeat (5) @(posedge clock);
        #1;
        resetN = 1'b0;
        @(posedge clock);
        @(negedge clock);
        checkOutput("midEncResetTsv", 1, tsvV[1], 0);
        checkOutput("midEncResetInReady", 1, inReady[1], 1);
        checkOutput("midEncResetOutValid", 1, outValid[1], 0);
        sbQ1.delete();
        @(posedge clock);
        #1;
        resetN = 1'b1;
        @(posedge clock);
        #1;

        $display("[TB] random traffic with throttled out_ready");
        throttle = 3'b111;
        fork
            randomRun(0, 300);
            randomRun(1, 300);
            randomRun(2, 300);
        join
        throttle = 3'b000;
        seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clock);
            seen = (sbSize(0) == 0) && (sbSize(1) == 0) && (sbSize(2) == 0);
        end
        if (!seen) reportFail("drainTimeout", 0);
        repeat (3) @(posedge clock);

        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end

endmodule
